player_shot_controller: RTL and testbench

Owns the player's single laser shot. It debounces-by-synchronisation and edge-detects the fire button, launches a shot from the cannon position, and moves the shot upward at a fixed rate. The shot is retired on a hit reported by `alien_controller` or when it leaves the playfield. The block drives `shot_active`, `shot_x` and `shot_y` straight into `alien_controller`, and drives a pixel overlay pipelined to match the alien overlay latency.

---
 rtl/game_pkg.sv | 17 +
 rtl/btn_sync_edge.sv | 24 ++
 rtl/player_shot_controller.sv | 126 ++++++++++++
 tb/tb_player_shot_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants: screen extents, coordinate/colour widths, shot FSM encoding.
package game_pkg;
  localparam int COORD_W  = 11;
  localparam int COLOR_W  = 12;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PLAYER_Y = 440;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLYING   = 2'd1,
    ST_COOLDOWN = 2'd2
  } shot_state_t;
endpackage

// File: rtl/btn_sync_edge.sv
// Button synchroniser + rising-edge detect; rise is 2-3 clk after the raw edge.
// No backpressure; pause freezes the sync/prev flops so edges seen only while paused are lost.
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic pause,
  input  logic btn,
  output logic rise
);
  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= 2'b00;
      prev <= 1'b0;
    end else if (!pause) begin
      sync <= {sync[0], btn};
      prev <= sync[1];
    end
  end

  assign rise = ~pause & sync[1] & ~prev;
endmodule

// File: rtl/player_shot_controller.sv
// Player laser shot: launch on fire edge, climb one step per move tick, retire on hit or top edge.
// Shot state valid 1 clk after fire_rise; pixel overlay has 2 clk latency; no backpressure, pause holds all game state.
module player_shot_controller
  import game_pkg::*;
#(
  parameter int     SHOT_WIDTH      = 2,
  parameter int     SHOT_HEIGHT     = 8,
  parameter int     PLAYER_Y        = game_pkg::PLAYER_Y,
  parameter int     Y_TOP           = 20,
  parameter int     SHOT_VELOCITY   = 4,
  parameter int     SHOT_INTERVAL   = 200000,
  parameter int     COOLDOWN_CYCLES = 5000000,
  parameter color_t SHOT_COLOR      = 12'hFF0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pause,
  input  logic               fire_btn,
  input  logic [COORD_W-1:0] player_x,
  input  logic               shot_hit,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  output logic               shot_active,
  output logic [COORD_W-1:0] shot_x,
  output logic [COORD_W-1:0] shot_y,
  output logic               shot_on,
  output logic [COLOR_W-1:0] shot_rgb
);
  localparam int MV_W   = $clog2(SHOT_INTERVAL + 1);
  localparam int COOL_W = $clog2(COOLDOWN_CYCLES + 1);

  typedef logic [COORD_W:0] wide_t;

  localparam logic [MV_W-1:0]   MV_LAST   = MV_W'(SHOT_INTERVAL - 1);
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN_CYCLES - 1);
  localparam coord_t            LAUNCH_Y  = COORD_W'(PLAYER_Y - SHOT_HEIGHT);
  localparam coord_t            MISS_Y    = COORD_W'(Y_TOP + SHOT_VELOCITY);
  localparam coord_t            STEP_Y    = COORD_W'(SHOT_VELOCITY);
  localparam wide_t             HALF_W    = wide_t'(SHOT_WIDTH / 2);
  localparam wide_t             FULL_W    = wide_t'(SHOT_WIDTH);
  localparam wide_t             FULL_H    = wide_t'(SHOT_HEIGHT);

  shot_state_t       state;
  logic              fire_rise;
  logic [MV_W-1:0]   mv_cnt;
  logic [COOL_W-1:0] cool_cnt;

  btn_sync_edge u_fire_sync (
    .clk   (clk),
    .reset (reset),
    .pause (pause),
    .btn   (fire_btn),
    .rise  (fire_rise)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      shot_active <= 1'b0;
      shot_x      <= '0;
      shot_y      <= '0;
      mv_cnt      <= '0;
      cool_cnt    <= '0;
    end else if (!pause) begin
      case (state)
        ST_IDLE: begin
          if (fire_rise) begin
            state       <= ST_FLYING;
            shot_active <= 1'b1;
            shot_x      <= player_x;
            shot_y      <= LAUNCH_Y;
            mv_cnt      <= '0;
          end
        end
        ST_FLYING: begin
          // A hit wins over a same-cycle move tick; position freezes where it was struck.
          if (shot_hit) begin
            state       <= ST_COOLDOWN;
            shot_active <= 1'b0;
            cool_cnt    <= COOL_LOAD;
          end else if (mv_cnt == MV_LAST) begin
            mv_cnt <= '0;
            if (shot_y < MISS_Y) begin
              state       <= ST_COOLDOWN;
              shot_active <= 1'b0;
              cool_cnt    <= COOL_LOAD;
            end else begin
              shot_y <= shot_y - STEP_Y;
            end
          end else begin
            mv_cnt <= mv_cnt + 1'b1;
          end
        end
        ST_COOLDOWN: begin
          if (cool_cnt == '0) state <= ST_IDLE;
          else                cool_cnt <= cool_cnt - 1'b1;
        end
        default: begin
          state       <= ST_IDLE;
          shot_active <= 1'b0;
        end
      endcase
    end
  end

  // Offset pixel_x by half the width instead of shot_x so the compare never wraps near column 0.
  logic  in_x, in_y, hit_s1;
  wide_t px_adj;

  assign px_adj = wide_t'(pixel_x) + HALF_W;
  assign in_x   = (px_adj >= wide_t'(shot_x)) && (px_adj < wide_t'(shot_x) + FULL_W);
  assign in_y   = (wide_t'(pixel_y) >= wide_t'(shot_y)) &&
                  (wide_t'(pixel_y) < wide_t'(shot_y) + FULL_H);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_s1   <= 1'b0;
      shot_on  <= 1'b0;
      shot_rgb <= '0;
    end else begin
      hit_s1   <= shot_active & in_x & in_y;
      shot_on  <= hit_s1;
      shot_rgb <= hit_s1 ? SHOT_COLOR : '0;
    end
  end
endmodule

// File: tb/tb_player_shot_controller.sv
// Randomised + directed bench for player_shot_controller against an elapsed-time reference model.
module tb_player_shot_controller;
  localparam int INTERVAL = 4;
  localparam int COOL     = 10;
  localparam int Y_TOP    = 20;
  localparam int VEL      = 4;
  localparam int SH       = 8;
  localparam int SW       = 2;
  localparam int PY       = 440;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pause = 1'b0;
  logic        fire_btn = 1'b0;
  logic        shot_hit = 1'b0;
  logic [10:0] player_x = 11'd0;
  logic [10:0] pixel_x = 11'd0;
  logic [10:0] pixel_y = 11'd0;
  logic        shot_active;
  logic [10:0] shot_x, shot_y;
  logic        shot_on;
  logic [11:0] shot_rgb;

  always #5 clk = ~clk;

  player_shot_controller #(
    .SHOT_WIDTH(SW), .SHOT_HEIGHT(SH), .PLAYER_Y(PY), .Y_TOP(Y_TOP),
    .SHOT_VELOCITY(VEL), .SHOT_INTERVAL(INTERVAL), .COOLDOWN_CYCLES(COOL),
    .SHOT_COLOR(12'hFF0)
  ) dut (
    .clk(clk), .reset(reset), .pause(pause), .fire_btn(fire_btn),
    .player_x(player_x), .shot_hit(shot_hit), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .shot_active(shot_active), .shot_x(shot_x), .shot_y(shot_y),
    .shot_on(shot_on), .shot_rgb(shot_rgb)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model in terms of unpaused elapsed time: launch time, retire deadline, position.
  int t_act, fly_start, cool_end, m_x, m_y;
  bit m_fly, ov1, ov2;
  bit hist[$];

  function void model_reset();
    t_act = 0; fly_start = 0; cool_end = 0; m_x = 0; m_y = 0;
    m_fly = 1'b0; ov1 = 1'b0; ov2 = 1'b0;
    hist = '{1'b0, 1'b0, 1'b0};
  endfunction

  function bit tick_now();
    return m_fly && (((t_act - fly_start) % INTERVAL) == INTERVAL - 1);
  endfunction

  function bit in_shot(int px, int py);
    return m_fly && px >= m_x - SW/2 && px < m_x - SW/2 + SW && py >= m_y && py < m_y + SH;
  endfunction

  function void model_step();
    bit rise;
    ov2 = ov1;
    ov1 = in_shot(int'(pixel_x), int'(pixel_y));
    if (!pause) begin
      // button seen two unpaused samples late; edge = newer sample high, older low
      rise = hist[1] && !hist[2];
      if (m_fly) begin
        if (shot_hit) begin
          m_fly = 1'b0; cool_end = t_act + 1 + COOL;
        end else if (tick_now()) begin
          if (m_y < Y_TOP + VEL) begin
            m_fly = 1'b0; cool_end = t_act + 1 + COOL;
          end else m_y = m_y - VEL;
        end
      end else if (t_act >= cool_end && rise) begin
        m_fly = 1'b1; fly_start = t_act + 1; m_x = int'(player_x); m_y = PY - SH;
      end
      hist.push_front(fire_btn);
      void'(hist.pop_back());
      t_act++;
    end
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("active", shot_active, m_fly);
    chk("shot_x", shot_x, m_x);
    chk("shot_y", shot_y, m_y);
    chk("shot_on", shot_on, ov2);
    chk("shot_rgb", shot_rgb, ov2 ? 32'hFF0 : 32'h0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, px, py, y0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_active", shot_active, 0);
    chk("rst_x", shot_x, 0);
    chk("rst_y", shot_y, 0);
    chk("rst_on", shot_on, 0);
    chk("rst_rgb", shot_rgb, 0);
    reset = 1'b1;
    model_reset();
    repeat (3) cyc();

    // launch from column 320, held button
    player_x = 11'd320;
    fire_btn = 1'b1;
    k = 0;
    while (!m_fly && k < 20) begin cyc(); k++; end
    chk("launch_wait", shot_active, 1);
    chk("launch_x", shot_x, 320);
    chk("launch_y", shot_y, 432);
    player_x = 11'd100;
    repeat (INTERVAL) cyc();
    chk("first_move", shot_y, 428);
    chk("x_latched", shot_x, 320);

    // pause mid-flight
    y0 = int'(shot_y);
    pause = 1'b1;
    repeat (50) cyc();
    chk("pause_hold_y", shot_y, y0);
    pause = 1'b0;

    // second press while flying, then free flight to the top
    fire_btn = 1'b0;
    repeat (3) cyc();
    fire_btn = 1'b1;
    k = 0;
    while (m_fly && k < 1000) begin cyc(); k++; end
    chk("miss_active", shot_active, 0);
    chk("miss_y", shot_y, 20);
    fire_btn = 1'b0;
    cyc();
    fire_btn = 1'b1;
    repeat (12) cyc();
    chk("cool_ignore", shot_active, 0);
    fire_btn = 1'b0;
    player_x = 11'd320;
    repeat (3) cyc();
    fire_btn = 1'b1;
    k = 0;
    while (!m_fly && k < 20) begin cyc(); k++; end
    chk("relaunch", shot_active, 1);

    // hit coinciding with a move tick at y=300
    k = 0;
    while (!(m_fly && m_y == 300 && tick_now()) && k < 1000) begin cyc(); k++; end
    chk("wait_y300", shot_y, 300);
    shot_hit = 1'b1;
    cyc();
    shot_hit = 1'b0;
    chk("hit_active", shot_active, 0);
    chk("hit_y", shot_y, 300);
    chk("hit_x", shot_x, 320);

    // overlay probe with the shot parked at (320,200)
    fire_btn = 1'b0;
    repeat (12) cyc();
    fire_btn = 1'b1;
    k = 0;
    while (!m_fly && k < 20) begin cyc(); k++; end
    k = 0;
    while (!(m_fly && m_y == 200) && k < 1000) begin cyc(); k++; end
    chk("wait_y200", shot_y, 200);
    pause = 1'b1;
    pixel_x = 11'd320; pixel_y = 11'd203;
    cyc();
    pixel_x = 11'd322; pixel_y = 11'd203;
    cyc();
    chk("ov_in_on", shot_on, 1);
    chk("ov_in_rgb", shot_rgb, 32'hFF0);
    pixel_x = 11'd0; pixel_y = 11'd0;
    cyc();
    chk("ov_out_on", shot_on, 0);
    chk("ov_out_rgb", shot_rgb, 0);
    pause = 1'b0;
    repeat (5) cyc();

    // asynchronous reset mid-flight
    fire_btn = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_active", shot_active, 0);
    chk("arst_x", shot_x, 0);
    chk("arst_y", shot_y, 0);
    chk("arst_on", shot_on, 0);
    chk("arst_rgb", shot_rgb, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    repeat (10) cyc();
    chk("post_rst_idle", shot_active, 0);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) fire_btn = ~fire_btn;
      shot_hit = ($urandom_range(19) == 0);
      if ($urandom_range(29) == 0) pause = ~pause;
      if ($urandom_range(15) == 0) player_x = 11'($urandom_range(631, 8));
      if ($urandom_range(1) == 1) begin
        px = m_x + int'($urandom_range(4)) - 2;
        py = m_y + int'($urandom_range(11)) - 2;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
      end else begin
        px = int'($urandom_range(639));
        py = int'($urandom_range(479));
      end
      pixel_x = 11'(px);
      pixel_y = 11'(py);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
